// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: FSM encoding, round count, rotate schedule
// and the PC-1 / PC-2 permutations (FIPS bit 1 is the MSB of each vector).
package des_pkg;

   localparam int ROUNDS = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // 64-bit key -> 56-bit {C,D}; parity bits are dropped.
   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = '0;
      for (int j = 0; j < 56; j++) begin
         cd[55-j] = key[64-PC1_TBL[j]];
      end
      return cd;
   endfunction

   // 56-bit {C,D} -> 48-bit round subkey.
   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] sk;
      sk = '0;
      for (int j = 0; j < 48; j++) begin
         sk[47-j] = cd[56-PC2_TBL[j]];
      end
      return sk;
   endfunction

   // SHIFT[k] for k = 1..16: rounds 1, 2, 9 and 16 rotate by one, all others by two.
   function automatic logic shift_two(input logic [4:0] k);
      logic two;
      case (k)
         5'd1, 5'd2, 5'd9, 5'd16: two = 1'b0;
         default:                 two = 1'b1;
      endcase
      return two;
   endfunction

endpackage

// File: rtl/des_rotate28.sv
// 28-bit circular rotate by one or two positions, left or right.
module des_rotate28 (
   input  logic [27:0] din,
   input  logic        two,
   input  logic        right,
   output logic [27:0] dout
);

   always_comb begin
      dout = din;
      case ({right, two})
         2'b00:   dout = {din[26:0], din[27]};
         2'b01:   dout = {din[25:0], din[27:26]};
         2'b10:   dout = {din[0], din[27:1]};
         2'b11:   dout = {din[1:0], din[27:2]};
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key scheduler: streams the sixteen 48-bit round subkeys over a
// valid/ready port, K1..K16 for encryption or K16..K1 for decryption.
module des_key_schedule #(
   parameter int PARITY_CHECK = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] key_in,
   input  logic        start,
   input  logic        decrypt,
   output logic [47:0] subkey,
   output logic        sk_valid,
   input  logic        sk_ready,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        done,
   output logic        key_err
);
   import des_pkg::*;

   // Handshake: a subkey moves when sk_valid & sk_ready on a rising edge; while
   // sk_valid is high and sk_ready low, subkey and round_idx hold and no state moves.

   state_t      state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [4:0]  r_q, r_d;
   logic        dec_q, dec_d;
   logic        sk_valid_q, sk_valid_d;
   logic        done_q, done_d;
   logic        key_err_q, key_err_d;

   logic [55:0] rot_src, rot_out;
   logic        rot_two, rot_right;
   logic        parity_ok, load, xfer;

   always_comb begin
      parity_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (!(^key_in[8*i +: 8])) parity_ok = 1'b0;
      end
   end

   assign load = (state_q == ST_IDLE) && start && ((PARITY_CHECK == 0) || parity_ok);
   assign xfer = sk_valid_q & sk_ready;

   // One shared rotator pair: fed from PC1(key_in) at load, from C/D while running.
   always_comb begin
      rot_src   = cd_q;
      rot_two   = 1'b0;
      rot_right = 1'b0;
      if (state_q == ST_IDLE) begin
         rot_src = pc1(key_in);
         rot_two = shift_two(5'd1);
      end else if (dec_q) begin
         rot_right = 1'b1;
         rot_two   = shift_two(5'd17 - r_q);
      end else begin
         rot_two   = shift_two(r_q + 5'd1);
      end
   end

   des_rotate28 u_rot_c (
      .din   (rot_src[55:28]),
      .two   (rot_two),
      .right (rot_right),
      .dout  (rot_out[55:28])
   );

   des_rotate28 u_rot_d (
      .din   (rot_src[27:0]),
      .two   (rot_two),
      .right (rot_right),
      .dout  (rot_out[27:0])
   );

   always_comb begin
      state_d    = state_q;
      cd_d       = cd_q;
      r_d        = r_q;
      dec_d      = dec_q;
      sk_valid_d = sk_valid_q;
      done_d     = 1'b0;
      key_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d    = ST_RUN;
               // Decrypt starts at K16, and C16D16 equals C0D0, so no rotation.
               cd_d       = decrypt ? rot_src : rot_out;
               r_d        = 5'd1;
               dec_d      = decrypt;
               sk_valid_d = 1'b1;
            end else if (start) begin
               key_err_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (r_q == 5'(ROUNDS)) begin
                  state_d    = ST_IDLE;
                  sk_valid_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  r_d  = r_q + 5'd1;
                  cd_d = rot_out;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cd_q       <= '0;
         r_q        <= 5'd1;
         dec_q      <= 1'b0;
         sk_valid_q <= 1'b0;
         done_q     <= 1'b0;
         key_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cd_q       <= cd_d;
         r_q        <= r_d;
         dec_q      <= dec_d;
         sk_valid_q <= sk_valid_d;
         done_q     <= done_d;
         key_err_q  <= key_err_d;
      end
   end

   assign subkey    = pc2(cd_q);
   assign sk_valid  = sk_valid_q;
   assign round_idx = dec_q ? 4'(5'd16 - r_q) : 4'(r_q - 5'd1);
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign key_err   = key_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: golden vectors, random keys with
// backpressure, busy/done-cycle starts, parity rejection and mid-sequence reset.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] key_in = '0;
   logic        start = 1'b0;
   logic        decrypt = 1'b0;
   logic        sk_ready = 1'b1;

   logic [47:0] subkey, np_subkey;
   logic        sk_valid, np_sk_valid;
   logic [3:0]  round_idx, np_round_idx;
   logic        busy, np_busy, done, np_done, key_err, np_key_err;

   always #5 clk = ~clk;

   des_key_schedule #(.PARITY_CHECK(1)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .start(start), .decrypt(decrypt),
      .subkey(subkey), .sk_valid(sk_valid), .sk_ready(sk_ready), .round_idx(round_idx),
      .busy(busy), .done(done), .key_err(key_err)
   );

   des_key_schedule #(.PARITY_CHECK(0)) dut_np (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .start(start), .decrypt(decrypt),
      .subkey(np_subkey), .sk_valid(np_sk_valid), .sk_ready(sk_ready), .round_idx(np_round_idx),
      .busy(np_busy), .done(np_done), .key_err(np_key_err)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (FIPS 46 rules, cumulative rotation) ----------------
   int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                      19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   logic [47:0] model_k [16];

   task automatic build_model(input logic [63:0] key);
      int c0 [28];
      int d0 [28];
      int cd [56];
      int tot;
      logic [47:0] k;
      for (int j = 0; j < 28; j++) begin
         c0[j] = int'(key[64-pc1_t[j]]);
         d0[j] = int'(key[64-pc1_t[28+j]]);
      end
      tot = 0;
      for (int r = 0; r < 16; r++) begin
         tot += sh_t[r];
         for (int j = 0; j < 28; j++) begin
            cd[j]    = c0[(j + tot) % 28];
            cd[28+j] = d0[(j + tot) % 28];
         end
         k = '0;
         for (int p = 0; p < 48; p++) k[47-p] = (cd[pc2_t[p]-1] != 0);
         model_k[r] = k;
      end
   endtask

   function automatic logic [63:0] odd_parity(input logic [63:0] k);
      logic [63:0] r;
      r = k;
      for (int i = 0; i < 8; i++) r[8*i] = ~^r[8*i+1 +: 7];
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   logic [47:0] exp_q [$];
   logic [3:0]  exp_idx_q [$];
   int          xfer_cnt = 0;
   logic        stalled = 1'b0;
   logic [47:0] last_sk = '0;
   logic [3:0]  last_idx = '0;
   logic [47:0] last_xfer_sk = '0;
   logic [3:0]  last_xfer_idx = '0;

   task automatic push_expected(input logic dec);
      for (int i = 0; i < 16; i++) begin
         int idx;
         idx = dec ? 15 - i : i;
         exp_q.push_back(model_k[idx]);
         exp_idx_q.push_back(4'(idx));
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 64'(sk_valid), 64'd1);
            check("stall_subkey", 64'(subkey), 64'(last_sk));
            check("stall_idx", 64'(round_idx), 64'(last_idx));
         end
         if (sk_valid && sk_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_xfer: got subkey %h with no expected entry", subkey);
            end else begin
               check("xfer_subkey", 64'(subkey), 64'(exp_q.pop_front()));
               check("xfer_idx", 64'(round_idx), 64'(exp_idx_q.pop_front()));
            end
            xfer_cnt++;
            last_xfer_sk  = subkey;
            last_xfer_idx = round_idx;
         end
         stalled  = sk_valid && !sk_ready;
         last_sk  = subkey;
         last_idx = round_idx;
      end
   end

   // ---------------- drivers ----------------
   bit rand_ready = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         sk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic do_start(input logic [63:0] key, input logic dec);
      @(posedge clk);
      #1;
      key_in  = key;
      decrypt = dec;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      key_in  = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string name, input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < budget);
      check({name, "_done_seen"}, 64'(done), 64'd1);
   endtask

   task automatic check_idle_after(input string name);
      @(negedge clk);
      check({name, "_done_pulse"}, 64'(done), 64'd0);
      check({name, "_busy_low"}, 64'(busy), 64'd0);
      check({name, "_valid_low"}, 64'(sk_valid), 64'd0);
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      logic [63:0] key;
      logic        dec;
      logic [47:0] first;
      logic [3:0]  first_idx;
      logic [47:0] last;
      logic [3:0]  last_idx;
   } vec_t;

   localparam logic [63:0] GOLD_KEY = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] ALT_KEY  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] BAD_KEY  = 64'h1334_5779_9BBC_DFF0;

   initial begin
      vec_t vecs [2];
      int   cyc;
      int   base;
      logic [63:0] rkey;
      logic        rdec;

      vecs[0] = '{GOLD_KEY, 1'b0, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
      vecs[1] = '{GOLD_KEY, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_subkey", 64'(subkey), 64'd0);
      check("rst_valid", 64'(sk_valid), 64'd0);
      check("rst_idx", 64'(round_idx), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_key_err", 64'(key_err), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // golden vectors, sk_ready high
      rand_ready = 1'b0;
      for (int v = 0; v < 2; v++) begin
         build_model(vecs[v].key);
         push_expected(vecs[v].dec);
         do_start(vecs[v].key, vecs[v].dec);
         @(negedge clk);
         check("vec_first_valid", 64'(sk_valid), 64'd1);
         check("vec_first_subkey", 64'(subkey), 64'(vecs[v].first));
         check("vec_first_idx", 64'(round_idx), 64'(vecs[v].first_idx));
         check("vec_busy", 64'(busy), 64'd1);
         wait_done("vec", 40, cyc);
         check("vec_done_latency", 64'(cyc), 64'd16);
         check("vec_last_subkey", 64'(last_xfer_sk), 64'(vecs[v].last));
         check("vec_last_idx", 64'(last_xfer_idx), 64'(vecs[v].last_idx));
         check_idle_after("vec");
      end

      // random keys and direction under random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         rkey = odd_parity({$urandom, $urandom});
         rdec = 1'($urandom_range(0, 1));
         build_model(rkey);
         push_expected(rdec);
         do_start(rkey, rdec);
         wait_done("rand", 300, cyc);
         check_idle_after("rand");
      end

      // golden key again under backpressure, with a start pulsed while busy
      build_model(GOLD_KEY);
      push_expected(1'b0);
      do_start(GOLD_KEY, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      key_in  = ALT_KEY;
      decrypt = 1'b1;
      start   = 1'b1;
      @(negedge clk);
      check("busy_during_start", 64'(busy), 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("busy_start", 300, cyc);
      check_idle_after("busy_start");

      // start raised during the done cycle is accepted
      rand_ready = 1'b0;
      build_model(GOLD_KEY);
      push_expected(1'b0);
      do_start(GOLD_KEY, 1'b0);
      wait_done("done_cyc_a", 40, cyc);
      build_model(ALT_KEY);
      push_expected(1'b0);
      key_in  = ALT_KEY;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("done_cyc_valid", 64'(sk_valid), 64'd1);
      check("done_cyc_subkey", 64'(subkey), 64'(model_k[0]));
      wait_done("done_cyc_b", 40, cyc);
      check_idle_after("done_cyc_b");

      // bad parity: rejected with key_err; the non-checking instance accepts it
      build_model(BAD_KEY);
      @(posedge clk);
      #1;
      key_in  = BAD_KEY;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("par_key_err", 64'(key_err), 64'd1);
      check("par_busy", 64'(busy), 64'd0);
      check("par_valid", 64'(sk_valid), 64'd0);
      check("par_np_valid", 64'(np_sk_valid), 64'd1);
      check("par_np_subkey", 64'(np_subkey), 64'(model_k[0]));
      check("par_np_key_err", 64'(np_key_err), 64'd0);
      @(negedge clk);
      check("par_key_err_pulse", 64'(key_err), 64'd0);
      check("par_valid_later", 64'(sk_valid), 64'd0);
      cyc = 0;
      while (!np_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("par_np_done", 64'(np_done), 64'd1);

      // reset after five transfers, then a fresh sequence
      build_model(GOLD_KEY);
      push_expected(1'b0);
      base = xfer_cnt;
      do_start(GOLD_KEY, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_xfers", 64'(xfer_cnt - base), 64'd5);
      check("mid_rst_subkey", 64'(subkey), 64'd0);
      check("mid_rst_valid", 64'(sk_valid), 64'd0);
      check("mid_rst_idx", 64'(round_idx), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      exp_q.delete();
      exp_idx_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_expected(1'b0);
      do_start(GOLD_KEY, 1'b0);
      @(negedge clk);
      check("post_rst_subkey", 64'(subkey), 64'h1B02EFFC7072);
      check("post_rst_idx", 64'(round_idx), 64'd0);
      wait_done("post_rst", 40, cyc);
      check_idle_after("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

endmodule
